aurora_rx_frame_monitor: RTL and testbench

//  Parametrised RX-side link monitor on the Aurora 8b10b LocalLink user interface (USER_CLK domain).

---
 rtl/aurora_chk_pkg.sv | 19 +
 rtl/aurora_prbs15_gen.sv | 43 ++++
 rtl/aurora_rx_frame_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_aurora_rx_frame_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_chk_pkg.sv
// Shared encodings for the Aurora RX frame monitor: check modes, PRBS-15
// polynomial/seed and the framing FSM state type.
package aurora_chk_pkg;

  localparam logic [1:0] MODE_CNT  = 2'b00;  // continuous counter
  localparam logic [1:0] MODE_FRM  = 2'b01;  // word index within frame
  localparam logic [1:0] MODE_PRBS = 2'b10;  // PRBS-15
  localparam logic [1:0] MODE_NONE = 2'b11;  // framing checks only

  // x^15 + x^14 + 1: feedback from state bits 14 and 13
  localparam logic [14:0] PRBS15_TAPS = 15'h6000;
  localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frm_state_t;

endpackage

// File: rtl/aurora_prbs15_gen.sv
// Parallel PRBS-15 generator: presents the next DATA_W sequence bits (first
// bit in the MSB) and steps the LFSR by DATA_W bits on advance.
module aurora_prbs15_gen
  import aurora_chk_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [DATA_W-1:0] word
);

  logic [14:0]       state;
  logic [14:0]       walk;
  logic [14:0]       state_nxt;
  logic              nb;
  logic [DATA_W-1:0] bits;

  // Unroll DATA_W serial steps of the Fibonacci LFSR
  always_comb begin
    walk = state;
    bits = '0;
    nb   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      nb               = ^(walk & PRBS15_TAPS);
      bits[DATA_W-1-i] = nb;
      walk             = {walk[13:0], nb};
    end
    state_nxt = walk;
  end

  assign word = bits;

  // LFSR state: seed on reset/clear, jump DATA_W bits per consumed word
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)      state <= PRBS15_SEED;
    else if (clear)   state <= PRBS15_SEED;
    else if (advance) state <= state_nxt;
  end

endmodule

// File: rtl/aurora_rx_frame_monitor.sv
// RX-side LocalLink monitor: framing FSM, payload checker (count / frame
// index / PRBS-15), saturating statistics counters and a snapshot of the
// first words of the latest frame.
module aurora_rx_frame_monitor
  import aurora_chk_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int REM_W         = 1,
  parameter int CAPTURE_DEPTH = 4,
  parameter int CNT_W         = 16,
  parameter int MAX_FRAME     = 256
) (
  input  logic                            USER_CLK,
  input  logic                            RESET_N,
  input  logic [0:DATA_W-1]               RX_D,
  input  logic [0:REM_W-1]                RX_REM,
  input  logic                            RX_SOF_N,
  input  logic                            RX_EOF_N,
  input  logic                            RX_SRC_RDY_N,
  input  logic                            CHANNEL_UP,
  input  logic [1:0]                      MODE,
  input  logic                            CLEAR_CNT,
  output logic [CAPTURE_DEPTH*DATA_W-1:0] CAPTURE_DATA,
  output logic [CNT_W-1:0]                DATA_ERR_CNT,
  output logic [CNT_W-1:0]                FRAME_ERR_CNT,
  output logic [CNT_W-1:0]                FRAME_CNT,
  output logic [CNT_W-1:0]                LINK_ERR_CNT,
  output logic                            ERR_PULSE,
  output logic                            IN_FRAME
);

  localparam int BYTES = DATA_W / 8;
  localparam int LW    = $clog2(MAX_FRAME + 1) + 1;
  // index must both cover the length limit and feed the per-frame pattern
  localparam int IW    = (DATA_W > LW) ? DATA_W : LW;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [2:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-2){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Big-endian LocalLink buses mapped so RX_D[0] lands in the MSB
  logic [DATA_W-1:0] d;
  logic [REM_W-1:0]  rem;
  assign d   = RX_D;
  assign rem = RX_REM;

  logic vld, sof, eof;
  assign vld = !RX_SRC_RDY_N && CHANNEL_UP;
  assign sof = vld && !RX_SOF_N;
  assign eof = vld && !RX_EOF_N;

  frm_state_t        state;
  logic [IW-1:0]     idx;       // index of the next in-frame word
  logic              len_err;   // current frame already overran MAX_FRAME
  logic [DATA_W-1:0] cnt_exp;
  logic [DATA_W-1:0] prbs_word;
  logic [CAPTURE_DEPTH-1:0][DATA_W-1:0] shadow, sh_nxt, cap_q;
  logic [1:0]        ch_sync;
  logic              ch_prev;

  logic              in_frm, frame_word, closing;
  logic [IW-1:0]     cur_idx;
  logic              fe_sof, fe_idle, fe_len, fe_rem;
  logic [2:0]        fe_inc;
  logic              frame_ok;
  logic [DATA_W-1:0] mask, exp_word;
  logic              chk_en, mism;
  logic              link_drop;

  assign in_frm     = (state == ST_IN_FRAME);
  assign frame_word = sof || (vld && in_frm);
  assign closing    = eof && frame_word;
  assign cur_idx    = sof ? '0 : idx;

  // Framing violations of the current word; an EOF-only word in IDLE is one error
  assign fe_sof  = sof && in_frm;
  assign fe_idle = vld && !in_frm && !sof;
  assign fe_len  = vld && in_frm && !sof && (idx >= IW'(MAX_FRAME)) && !len_err;
  assign fe_rem  = closing && (int'(rem) >= BYTES);
  assign fe_inc  = {2'b0, fe_sof} + {2'b0, fe_idle} + {2'b0, fe_len} + {2'b0, fe_rem};
  // A restarted frame (SOF) is fresh, so an older overrun does not taint it
  assign frame_ok = closing && !fe_rem && !fe_len && !(len_err && !sof);

  // Byte-enable mask for the compare: EOF word only checks bytes 0..RX_REM
  always_comb begin
    mask = '0;
    for (int b = 0; b < BYTES; b++)
      if (!eof || b <= int'(rem)) mask[DATA_W-1-8*b -: 8] = 8'hFF;
  end

  // Expected word per mode and whether this word is compared at all
  always_comb begin
    exp_word = '0;
    chk_en   = 1'b0;
    case (MODE)
      MODE_CNT:  begin exp_word = cnt_exp;               chk_en = vld;        end
      MODE_FRM:  begin exp_word = cur_idx[DATA_W-1:0];   chk_en = frame_word; end
      MODE_PRBS: begin exp_word = prbs_word;             chk_en = vld;        end
      default:   begin exp_word = '0;                    chk_en = 1'b0;       end
    endcase
  end

  assign mism = chk_en && (((d ^ exp_word) & mask) != '0);

  aurora_prbs15_gen #(.DATA_W(DATA_W)) u_prbs (
    .gclk    (USER_CLK),
    .grst_n  (RESET_N),
    .clear   (!CHANNEL_UP),
    .advance (vld && (MODE == MODE_PRBS)),
    .word    (prbs_word)
  );

  // Framing FSM, frame index and count-mode expectation; channel loss restarts them
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      idx     <= '0;
      len_err <= 1'b0;
      cnt_exp <= '0;
    end else if (!CHANNEL_UP) begin
      state   <= ST_IDLE;
      idx     <= '0;
      len_err <= 1'b0;
      cnt_exp <= '0;
    end else if (vld) begin
      if (sof && !eof) state <= ST_IN_FRAME;
      else if (eof)    state <= ST_IDLE;
      if (frame_word) begin
        idx     <= cur_idx + 1'b1;
        len_err <= sof ? 1'b0 : (len_err || fe_len);
      end
      if (MODE == MODE_CNT) cnt_exp <= mism ? d + 1'b1 : cnt_exp + 1'b1;
    end
  end

  // Shadow image of the frame head: cleared at SOF, first words written in
  always_comb begin
    sh_nxt = sof ? '0 : shadow;
    if (frame_word)
      for (int k = 0; k < CAPTURE_DEPTH; k++)
        if (cur_idx == IW'(k)) sh_nxt[k] = d;
  end

  // Shadow fill and publish on the EOF that closes a frame
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow <= '0;
      cap_q  <= '0;
    end else begin
      if (vld)     shadow <= sh_nxt;
      if (closing) cap_q  <= sh_nxt;
    end
  end

  assign CAPTURE_DATA = cap_q;

  // CHANNEL_UP resynchroniser plus delayed copy for falling-edge detect
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ch_sync <= '0;
      ch_prev <= 1'b0;
    end else begin
      ch_sync <= {ch_sync[0], CHANNEL_UP};
      ch_prev <= ch_sync[1];
    end
  end

  assign link_drop = ch_prev && !ch_sync[1];

  // Saturating statistics; a clear pulse beats any same-cycle increment
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DATA_ERR_CNT  <= '0;
      FRAME_ERR_CNT <= '0;
      FRAME_CNT     <= '0;
      LINK_ERR_CNT  <= '0;
    end else if (CLEAR_CNT) begin
      DATA_ERR_CNT  <= '0;
      FRAME_ERR_CNT <= '0;
      FRAME_CNT     <= '0;
      LINK_ERR_CNT  <= '0;
    end else begin
      if (mism)          DATA_ERR_CNT  <= sat_add(DATA_ERR_CNT, 3'd1);
      if (fe_inc != '0)  FRAME_ERR_CNT <= sat_add(FRAME_ERR_CNT, fe_inc);
      if (frame_ok)      FRAME_CNT     <= sat_add(FRAME_CNT, 3'd1);
      if (link_drop)     LINK_ERR_CNT  <= sat_add(LINK_ERR_CNT, 3'd1);
    end
  end

  // One-cycle error strobe following any offending word
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) ERR_PULSE <= 1'b0;
    else          ERR_PULSE <= mism || (fe_inc != '0);
  end

  assign IN_FRAME = in_frm;

endmodule

// File: tb/tb_aurora_rx_frame_monitor.sv
// Directed bench for aurora_rx_frame_monitor (DATA_W=32): count, frame-index
// and PRBS checking, framing errors, link drop, clear, saturation, reset.
module tb_aurora_rx_frame_monitor;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:31]   rx_d;
  logic [0:1]    rx_rem;
  logic          sof_n, eof_n, rdy_n;
  logic          channel_up;
  logic [1:0]    mode;
  logic          clear_cnt;
  logic [127:0]  capture;
  logic [15:0]   data_err, frame_err, frame_cnt, link_err;
  logic          err_pulse, in_frame;

  int checks = 0;
  int errors = 0;
  logic [14:0] lfsr;

  always #5 clk = ~clk;

  aurora_rx_frame_monitor #(
    .DATA_W(32), .REM_W(2), .CAPTURE_DEPTH(4), .CNT_W(16), .MAX_FRAME(256)
  ) dut (
    .USER_CLK(clk), .RESET_N(rst_n), .RX_D(rx_d), .RX_REM(rx_rem),
    .RX_SOF_N(sof_n), .RX_EOF_N(eof_n), .RX_SRC_RDY_N(rdy_n),
    .CHANNEL_UP(channel_up), .MODE(mode), .CLEAR_CNT(clear_cnt),
    .CAPTURE_DATA(capture), .DATA_ERR_CNT(data_err), .FRAME_ERR_CNT(frame_err),
    .FRAME_CNT(frame_cnt), .LINK_ERR_CNT(link_err), .ERR_PULSE(err_pulse),
    .IN_FRAME(in_frame)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic word(input logic [31:0] d, input bit sof, input bit eof, input logic [1:0] rem);
    @(negedge clk);
    rx_d = d; rdy_n = 1'b0; sof_n = !sof; eof_n = !eof; rx_rem = rem; clear_cnt = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rdy_n = 1'b1; sof_n = 1'b1; eof_n = 1'b1; clear_cnt = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) word(base + 32'(i), i == 0, i == n - 1, 2'd3);
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst_n = 1'b0; channel_up = 1'b0; mode = m;
    rdy_n = 1'b1; sof_n = 1'b1; eof_n = 1'b1; clear_cnt = 1'b0;
    rx_d = '0; rx_rem = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    channel_up = 1'b1;
    idle(4);
  endtask

  // Serial reference PRBS-15: y[n] = y[n-15] ^ y[n-14], first bit to the MSB
  function automatic logic [31:0] prbs_next();
    logic [31:0] w;
    logic nb;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      nb   = lfsr[14] ^ lfsr[13];
      lfsr = {lfsr[13:0], nb};
      w    = {w[30:0], nb};
    end
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;

    // ---- reset state
    rst_n = 1'b0; channel_up = 1'b0; mode = 2'b00;
    rdy_n = 1'b1; sof_n = 1'b1; eof_n = 1'b1; clear_cnt = 1'b0;
    rx_d = '0; rx_rem = '0;
    #12;
    chk("rst_capture", capture, 128'h0);
    chk("rst_data_err", data_err, 16'h0);
    chk("rst_frame_err", frame_err, 16'h0);
    chk("rst_frame_cnt", frame_cnt, 16'h0);
    chk("rst_link_err", link_err, 16'h0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_in_frame", in_frame, 1'b0);

    // ---- MODE 00: 10 frames x 8 words, data 0..79
    do_reset(2'b00);
    for (int f = 0; f < 10; f++) frame(8, 32'(f * 8));
    idle(2);
    chk("cnt_data_err", data_err, 16'd0);
    chk("cnt_frame_cnt", frame_cnt, 16'd10);
    chk("cnt_frame_err", frame_err, 16'd0);
    chk("cnt_capture", capture, {32'd75, 32'd74, 32'd73, 32'd72});

    // ---- MODE 00: 0x05 replaced by 0xFF, stream continues from 0x100
    do_reset(2'b00);
    for (int i = 0; i < 16; i++) begin
      w = (i < 5) ? 32'(i) : (i == 5) ? 32'hFF : 32'(32'hFA + i);
      word(w, i == 0, i == 15, 2'd3);
    end
    idle(2);
    chk("realign_data_err", data_err, 16'd1);
    // EOF with RX_REM=1: only upper two bytes compared, garbage below is ignored
    word(32'h10A, 1, 0, 2'd3); word(32'h10B, 0, 0, 2'd3);
    word(32'h10C, 0, 0, 2'd3); word(32'h0000DEAD, 0, 1, 2'd1);
    idle(2);
    chk("rem_mask_clean", data_err, 16'd1);
    chk("rem_frame_cnt", frame_cnt, 16'd2);
    word(32'h10E, 1, 0, 2'd3); word(32'hFFFF010F, 0, 1, 2'd1);
    idle(2);
    chk("rem_mask_err", data_err, 16'd2);

    // ---- MODE 01: index pattern, no realign
    do_reset(2'b01);
    frame(4, 32'd0);
    word(32'd0, 1, 0, 2'd3); word(32'd1, 0, 0, 2'd3);
    word(32'd9, 0, 0, 2'd3); word(32'd3, 0, 1, 2'd3);
    idle(2);
    chk("frm_data_err", data_err, 16'd1);
    chk("frm_frame_cnt", frame_cnt, 16'd2);

    // ---- MODE 10: PRBS-15, word 3 has bit flipped
    do_reset(2'b10);
    lfsr = 15'h7FFF;
    for (int i = 0; i < 6; i++) begin
      w = prbs_next();
      if (i == 0) w = 32'h0002000C;
      if (i == 3) w = w ^ 32'h0000_0080;
      word(w, i == 0, i == 5, 2'd3);
      if (i >= 2 && i <= 4) begin
        @(posedge clk); #1;
        chk($sformatf("prbs_pulse_w%0d", i), err_pulse, (i == 3));
      end
    end
    idle(2);
    chk("prbs_data_err", data_err, 16'd1);
    chk("prbs_frame_cnt", frame_cnt, 16'd1);

    // ---- framing errors, MODE 11
    do_reset(2'b11);
    word(32'd0, 0, 1, 2'd3);
    @(posedge clk); #1;
    chk("eof_idle_pulse", err_pulse, 1'b1);
    idle(2);
    chk("eof_idle_ferr", frame_err, 16'd1);
    chk("eof_idle_fcnt", frame_cnt, 16'd0);
    word(0, 1, 0, 3); word(0, 0, 0, 3); word(0, 0, 0, 3);
    word(0, 1, 0, 3); word(0, 0, 0, 3); word(0, 0, 1, 3);
    idle(2);
    chk("sof_in_frame_ferr", frame_err, 16'd2);
    chk("sof_in_frame_fcnt", frame_cnt, 16'd1);
    frame(256, 32'd0);
    idle(2);
    chk("len256_ferr", frame_err, 16'd2);
    chk("len256_fcnt", frame_cnt, 16'd2);
    for (int i = 0; i < 150; i++) word(0, i == 0, 0, 3);
    chk("long_in_frame", in_frame, 1'b1);
    for (int i = 150; i < 300; i++) word(0, 0, i == 299, 3);
    idle(2);
    chk("len300_ferr", frame_err, 16'd3);
    chk("len300_fcnt", frame_cnt, 16'd2);
    frame(257, 32'd0);
    idle(2);
    chk("len257_ferr", frame_err, 16'd4);
    word(0, 0, 0, 3); word(0, 0, 0, 3);
    idle(2);
    chk("idle_words_ferr", frame_err, 16'd6);
    word(0, 1, 1, 3);
    idle(2);
    chk("one_word_fcnt", frame_cnt, 16'd3);

    // ---- link drop mid-frame, then clear
    do_reset(2'b00);
    frame(8, 32'd0);
    word(8, 1, 0, 3); word(9, 0, 0, 3); word(10, 0, 0, 3);
    @(posedge clk); #1;
    chk("link_pre_in_frame", in_frame, 1'b1);
    @(negedge clk);
    rdy_n = 1'b1; channel_up = 1'b0;
    repeat (5) @(negedge clk);
    chk("link_in_frame", in_frame, 1'b0);
    channel_up = 1'b1;
    idle(3);
    chk("link_err", link_err, 16'd1);
    chk("link_fcnt_kept", frame_cnt, 16'd1);
    chk("link_capture_kept", capture, {32'd3, 32'd2, 32'd1, 32'd0});
    frame(8, 32'd0);
    idle(2);
    chk("link_realigned", data_err, 16'd0);
    chk("link_fcnt2", frame_cnt, 16'd2);
    word(32'd8, 1, 1, 3);
    clear_cnt = 1'b1;
    idle(2);
    chk("clr_fcnt", frame_cnt, 16'd0);
    chk("clr_link", link_err, 16'd0);
    chk("clr_data", data_err, 16'd0);

    // ---- saturation, then async reset mid-frame
    do_reset(2'b00);
    for (int i = 0; i < 65534; i++) word(32'hFFFFFFFF, 0, 0, 3);
    idle(2);
    chk("sat_pre_data", data_err, 16'hFFFE);
    chk("sat_pre_ferr", frame_err, 16'hFFFE);
    for (int i = 0; i < 3; i++) word(32'hFFFFFFFF, 0, 0, 3);
    idle(2);
    chk("sat_data", data_err, 16'hFFFF);
    chk("sat_ferr", frame_err, 16'hFFFF);
    frame(4, 32'hFFFFFFFF);
    word(5, 1, 0, 3); word(6, 0, 0, 3);
    @(posedge clk); #1;
    chk("pre_rst_capture", capture, {32'd2, 32'd1, 32'd0, 32'hFFFFFFFF});
    chk("pre_rst_in_frame", in_frame, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_capture", capture, 128'h0);
    chk("arst_data", data_err, 16'h0);
    chk("arst_ferr", frame_err, 16'h0);
    chk("arst_fcnt", frame_cnt, 16'h0);
    chk("arst_in_frame", in_frame, 1'b0);
    chk("arst_pulse", err_pulse, 1'b0);
    idle(2);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
